// File: rtl/tlp_fifo_pkg.sv
// Shared types and constants for the transaction-layer FIFO read side.
package tlp_fifo_pkg;

  localparam int DATA_W     = 10;
  localparam int SKID_DEPTH = 2;
  localparam int OCC_W      = $clog2(SKID_DEPTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    STOP = 2'd2
  } pop_state_e;

  // One-hot codes of the main state machine; the top level decodes these
  // into the active/reset strobes that feed the pop controller.
  localparam logic [3:0] SM_RESET  = 4'b0001;
  localparam logic [3:0] SM_INIT   = 4'b0010;
  localparam logic [3:0] SM_ACTIVE = 4'b0100;

  function automatic logic sm_is_active(input logic [3:0] code);
    return code == SM_ACTIVE;
  endfunction

  function automatic logic sm_is_reset(input logic [3:0] code);
    return code == SM_RESET;
  endfunction

endpackage

// File: rtl/fifo_pop_ctrl_if.sv
// Source-FIFO pop side and downstream valid/ready side of the pop controller.
interface fifo_pop_ctrl_if import tlp_fifo_pkg::*; #(parameter int WIDTH = DATA_W);

  logic             src_empty;
  logic [WIDTH-1:0] src_data;
  logic             src_pop;
  logic [WIDTH-1:0] dst_data;
  logic             dst_valid;
  logic             dst_ready;

  modport master (
    output src_pop, dst_data, dst_valid,
    input  src_empty, src_data, dst_ready
  );

  modport slave (
    input  src_pop, dst_data, dst_valid,
    output src_empty, src_data, dst_ready
  );

endinterface

// File: rtl/tlp_skid_buf2.sv
// Two-entry register buffer; head is always the oldest word.
module tlp_skid_buf2 import tlp_fifo_pkg::*; (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [OCC_W-1:0]  occ,
  output logic [DATA_W-1:0] head,
  output logic              head_valid
);

  logic [DATA_W-1:0] tail;

  // Push writes behind the current contents; pop shifts the tail forward.
  always_ff @(posedge clk) begin
    if (reset) begin
      occ        <= '0;
      head       <= '0;
      tail       <= '0;
      head_valid <= 1'b0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (occ == 2'd0) head <= push_data;
          else             tail <= push_data;
          occ        <= occ + 1'b1;
          head_valid <= 1'b1;
        end
        2'b01: begin
          head       <= tail;
          occ        <= occ - 1'b1;
          head_valid <= (occ == 2'd2);
        end
        2'b11: begin
          if (occ == 2'd2) begin
            head <= tail;
            tail <= push_data;
          end else begin
            head <= push_data;
          end
        end
        default: ;
      endcase
    end
  end

  // The pop rule upstream must never let a word arrive into a full buffer.
  a_no_overflow: assert property (@(posedge clk) disable iff (reset)
    !(push && !pop && occ == 2'd2));

endmodule

// File: rtl/fifo_pop_ctrl.sv
// Read-side controller: pops the source FIFO, captures returned words in a
// two-entry skid buffer and hands them downstream over valid/ready.
//
// state | meaning
// IDLE  | pops disabled, nothing held or in flight
// RUN   | pops enabled
// STOP  | no new pops; in-flight word captured, buffered words drained
module fifo_pop_ctrl import tlp_fifo_pkg::*; #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             active,
  fifo_pop_ctrl_if.master  bus,
  output logic             busy,
  output logic [CNT_W-1:0] word_count
);

  pop_state_e       state;
  logic             inflight;
  logic [OCC_W-1:0] occ;
  logic [2:0]       held;
  logic             deq;
  logic             pop_en;
  logic [CNT_W-1:0] cnt_q;

  assign deq    = bus.dst_valid && bus.dst_ready;
  assign held   = 3'(occ) + 3'(inflight);
  assign pop_en = (state == RUN);

  // dst_ready feeds the pop decision directly so a slot freed this cycle can
  // be refilled this cycle, which is what sustains one word per cycle.
  assign bus.src_pop = !reset && pop_en && !bus.src_empty &&
                       (held < (3'd2 + 3'(deq)));

  tlp_skid_buf2 u_skid (
    .clk        (clk),
    .reset      (reset),
    .push       (inflight),
    .push_data  (bus.src_data),
    .pop        (deq),
    .occ        (occ),
    .head       (bus.dst_data),
    .head_valid (bus.dst_valid)
  );

  // State sequencing, in-flight tracking and the registered busy flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      busy     <= 1'b0;
      inflight <= 1'b0;
    end else begin
      inflight <= bus.src_pop;
      case (state)
        IDLE: begin
          if (active) begin
            state <= RUN;
            busy  <= 1'b1;
          end
        end
        RUN: begin
          // A pop issued this cycle still owes a capture, so it counts as held.
          if (!active) begin
            if (held == 3'd0 && !bus.src_pop) begin
              state <= IDLE;
              busy  <= 1'b0;
            end else begin
              state <= STOP;
            end
          end
        end
        STOP: begin
          if (active) begin
            state <= RUN;
          end else if (occ == 2'd0 && !inflight) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // Delivered-word counter, saturating at all-ones.
  always_ff @(posedge clk) begin
    if (reset)                    cnt_q <= '0;
    else if (deq && cnt_q != '1)  cnt_q <= cnt_q + 1'b1;
  end

  assign word_count = cnt_q;

endmodule

// File: tb/tb_fifo_pop_ctrl.sv
// Bench for fifo_pop_ctrl: a fixed vector table for the basic sequence, then
// directed and random phases checked against a queue-based reference model.
module tb_fifo_pop_ctrl;
  import tlp_fifo_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        active;
  logic        busy;
  logic [15:0] word_count;

  fifo_pop_ctrl_if bus();

  fifo_pop_ctrl #(.CNT_W(16)) dut (
    .clk        (clk),
    .reset      (reset),
    .active     (active),
    .bus        (bus),
    .busy       (busy),
    .word_count (word_count)
  );

  always #5 clk = ~clk;

  localparam logic [9:0] JUNK = 10'h3C3;
  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_STOP = 2;

  int vectors     = 0;
  int miscompares = 0;
  int pops_seen   = 0;

  // Source FIFO seen by the DUT, plus the expected delivery order.
  logic [9:0] src_q[$];
  logic [9:0] sb_q[$];
  bit         pend;
  logic [9:0] pend_word;

  // Reference model: words held by the controller, one in-flight flag, mode.
  logic [9:0]  m_buf[$];
  bit          m_infl;
  int          m_mode;
  logic [15:0] m_count;

  typedef struct {
    bit          rst, act, rdy, emp;
    logic [9:0]  sd;
    bit          e_pop, e_valid, chk_d;
    logic [9:0]  e_data;
    bit          e_busy;
    logic [15:0] e_cnt;
  } vec_t;

  vec_t tbl[11];

  function automatic vec_t mk(bit rst, bit act, bit rdy, bit emp, logic [9:0] sd,
                              bit e_pop, bit e_valid, bit chk_d, logic [9:0] e_data,
                              bit e_busy, logic [15:0] e_cnt);
    vec_t v;
    v.rst = rst; v.act = act; v.rdy = rdy; v.emp = emp; v.sd = sd;
    v.e_pop = e_pop; v.e_valid = e_valid; v.chk_d = chk_d; v.e_data = e_data;
    v.e_busy = e_busy; v.e_cnt = e_cnt;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic load(input int n, input logic [9:0] base);
    for (int i = 0; i < n; i++) begin
      src_q.push_back(base + 10'(i));
      sb_q.push_back(base + 10'(i));
    end
  endtask

  // One clock cycle: drive inputs, compare against the model, advance model.
  task automatic step(input bit rst, input bit act, input bit rdy, input bit gate);
    bit         exp_valid, deq, exp_pop, exp_busy;
    int         held;
    logic [9:0] exp_data;
    reset         = rst;
    active        = act;
    bus.dst_ready = rdy;
    bus.src_empty = gate || (src_q.size() == 0);
    bus.src_data  = pend ? pend_word : JUNK;
    #1;
    exp_valid = (m_buf.size() != 0);
    exp_data  = exp_valid ? m_buf[0] : 10'h000;
    deq       = exp_valid && rdy;
    held      = m_buf.size() + int'(m_infl);
    exp_pop   = !rst && (m_mode == M_RUN) && !bus.src_empty && (held - int'(deq) < 2);
    exp_busy  = (m_mode != M_IDLE);
    vectors++;
    chk("src_pop",    32'(bus.src_pop),   32'(exp_pop));
    chk("dst_valid",  32'(bus.dst_valid), 32'(exp_valid));
    if (exp_valid) chk("dst_data", 32'(bus.dst_data), 32'(exp_data));
    chk("busy",       32'(busy),          32'(exp_busy));
    chk("word_count", 32'(word_count),    32'(m_count));
    if (!rst && bus.dst_valid && rdy) begin
      if (sb_q.size() == 0) chk("order extra word", 32'(bus.dst_data), 32'h3FF_FFFF);
      else                  chk("order", 32'(bus.dst_data), 32'(sb_q.pop_front()));
    end
    if (bus.src_pop) pops_seen++;
    pend = 1'b0;
    if (bus.src_pop && !bus.src_empty && src_q.size() != 0) begin
      pend_word = src_q.pop_front();
      pend      = 1'b1;
    end
    if (rst) begin
      m_buf.delete();
      m_infl  = 1'b0;
      m_count = 16'h0000;
      m_mode  = M_IDLE;
    end else begin
      case (m_mode)
        M_IDLE: if (act) m_mode = M_RUN;
        M_RUN:  if (!act) m_mode = (held == 0 && !exp_pop) ? M_IDLE : M_STOP;
        default: begin
          if (act) m_mode = M_RUN;
          else if (m_buf.size() == 0 && !m_infl) m_mode = M_IDLE;
        end
      endcase
      if (deq) begin
        void'(m_buf.pop_front());
        if (m_count != 16'hFFFF) m_count = m_count + 16'h0001;
      end
      if (m_infl) m_buf.push_back(bus.src_data);
      m_infl = exp_pop;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic run_active(input string nm, input int max);
    int n = 0;
    while ((src_q.size() != 0 || m_buf.size() != 0 || m_infl) && n < max) begin
      step(1'b0, 1'b1, 1'b1, 1'b0);
      n++;
    end
    if (n == max) begin
      miscompares++;
      $display("FAIL %s: timeout after %0d cycles, %0d words left", nm, n, src_q.size());
    end
  endtask

  task automatic drain(input string nm);
    int n = 0;
    while ((m_mode != M_IDLE || m_buf.size() != 0 || m_infl) && n < 40) begin
      step(1'b0, 1'b0, 1'b1, 1'b0);
      n++;
    end
    if (n == 40) begin
      miscompares++;
      $display("FAIL %s: drain timeout, busy %0b", nm, busy);
    end
    chk({nm, " busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    pend = 1'b0;
    pend_word = JUNK;
    reset = 1'b1;
    active = 1'b0;
    bus.dst_ready = 1'b0;
    bus.src_empty = 1'b1;
    bus.src_data = 10'h000;
    repeat (2) @(posedge clk);
    @(negedge clk);

    // Reset, then five words with dst_ready high; active drops at the end.
    tbl[0]  = mk(1'b1, 1'b1, 1'b1, 1'b0, JUNK,   1'b0, 1'b0, 1'b1, 10'h000, 1'b0, 16'd0);
    tbl[1]  = mk(1'b0, 1'b1, 1'b1, 1'b0, JUNK,   1'b0, 1'b0, 1'b1, 10'h000, 1'b0, 16'd0);
    tbl[2]  = mk(1'b0, 1'b1, 1'b1, 1'b0, JUNK,   1'b1, 1'b0, 1'b1, 10'h000, 1'b1, 16'd0);
    tbl[3]  = mk(1'b0, 1'b1, 1'b1, 1'b0, 10'h001, 1'b1, 1'b0, 1'b1, 10'h000, 1'b1, 16'd0);
    tbl[4]  = mk(1'b0, 1'b1, 1'b1, 1'b0, 10'h002, 1'b1, 1'b1, 1'b1, 10'h001, 1'b1, 16'd0);
    tbl[5]  = mk(1'b0, 1'b1, 1'b1, 1'b0, 10'h003, 1'b1, 1'b1, 1'b1, 10'h002, 1'b1, 16'd1);
    tbl[6]  = mk(1'b0, 1'b1, 1'b1, 1'b0, 10'h004, 1'b1, 1'b1, 1'b1, 10'h003, 1'b1, 16'd2);
    tbl[7]  = mk(1'b0, 1'b0, 1'b1, 1'b1, 10'h005, 1'b0, 1'b1, 1'b1, 10'h004, 1'b1, 16'd3);
    tbl[8]  = mk(1'b0, 1'b0, 1'b1, 1'b1, JUNK,   1'b0, 1'b1, 1'b1, 10'h005, 1'b1, 16'd4);
    tbl[9]  = mk(1'b0, 1'b0, 1'b1, 1'b1, JUNK,   1'b0, 1'b0, 1'b0, 10'h000, 1'b1, 16'd5);
    tbl[10] = mk(1'b0, 1'b0, 1'b1, 1'b1, JUNK,   1'b0, 1'b0, 1'b0, 10'h000, 1'b0, 16'd5);

    for (int i = 0; i < 11; i++) begin
      reset         = tbl[i].rst;
      active        = tbl[i].act;
      bus.dst_ready = tbl[i].rdy;
      bus.src_empty = tbl[i].emp;
      bus.src_data  = tbl[i].sd;
      #1;
      vectors++;
      chk($sformatf("tbl%0d src_pop", i),    32'(bus.src_pop),   32'(tbl[i].e_pop));
      chk($sformatf("tbl%0d dst_valid", i),  32'(bus.dst_valid), 32'(tbl[i].e_valid));
      if (tbl[i].chk_d) chk($sformatf("tbl%0d dst_data", i), 32'(bus.dst_data), 32'(tbl[i].e_data));
      chk($sformatf("tbl%0d busy", i),       32'(busy),          32'(tbl[i].e_busy));
      chk($sformatf("tbl%0d word_count", i), 32'(word_count),    32'(tbl[i].e_cnt));
      @(posedge clk);
      @(negedge clk);
    end

    // Model picks up where the table left the DUT.
    m_buf.delete();
    m_infl  = 1'b0;
    m_mode  = M_IDLE;
    m_count = 16'd5;
    step(1'b1, 1'b0, 1'b1, 1'b0);

    // Back-pressure: 8 words, dst_ready low for 8 cycles from activation.
    load(8, 10'h010);
    pops_seen = 0;
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 1'b0, 1'b0);
    chk("bp pops", 32'(pops_seen), 32'd2);
    chk("bp head valid", 32'(bus.dst_valid), 32'd1);
    chk("bp head data", 32'(bus.dst_data), 32'h010);
    run_active("bp release", 40);
    drain("bp");
    chk("bp count", 32'(word_count), 32'd8);

    // Active drops the cycle after the first pop.
    load(4, 10'h040);
    pops_seen = 0;
    for (int n = 0; n < 10 && pops_seen == 0; n++) step(1'b0, 1'b1, 1'b1, 1'b0);
    chk("drop first pop", 32'(pops_seen), 32'd1);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    pops_seen = 0;
    drain("drop");
    chk("drop later pops", 32'(pops_seen), 32'd0);

    // Reset with the buffer holding words.
    load(3, 10'h080);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b0, 1'b0);
    chk("pre-rst valid", 32'(bus.dst_valid), 32'd1);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    src_q.delete();
    sb_q.delete();
    chk("rst dst_valid", 32'(bus.dst_valid), 32'd0);
    chk("rst word_count", 32'(word_count), 32'd0);
    pend      = 1'b1;
    pend_word = 10'h2BD;
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b1, 1'b0);
    chk("post-rst dst_valid", 32'(bus.dst_valid), 32'd0);

    // Random: empty gated every other cycle, random ready, occasional active drops.
    load(60, 10'h100);
    for (int i = 0; i < 400; i++)
      step(1'b0, ($urandom_range(0, 15) != 0), 1'($urandom_range(0, 1)), 1'(i % 2));
    run_active("rand flush", 200);
    drain("rand");
    chk("rand words left", 32'(sb_q.size()), 32'd0);

    // Counter saturation.
    force dut.cnt_q = 16'hFFFE;
    #1;
    release dut.cnt_q;
    m_count = 16'hFFFE;
    load(3, 10'h1F0);
    run_active("sat", 40);
    drain("sat");
    chk("sat count", 32'(word_count), 32'hFFFF);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, 1'b0);
    chk("sat hold", 32'(word_count), 32'hFFFF);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
